alu_host_sequencer: RTL and testbench
=====================================

// Module: alu_host_sequencer
// PURPOSE
//  Initiator side of the ALU control-unit protocol. Accepts one operation request per
//  valid/ready handshake, pulses BEGIN and drives op_code, then feeds the operand words
//  onto inbus in the order the ALU loads them. It captures the words the ALU pushes on
//  outbus and returns them as a {hi,lo} response. Sits between system logic and the ALU top.
// PARAMETERS
//  WIDTH          8    ALU word width (inbus/outbus, A/Q/M registers)
//  TIMEOUT_CYCLES 255  watchdog limit, counted in cycles from START; must be >= 1
// PORTS
//  clk       in   1        clock, rising edge
//  reset     in   1        synchronous, active-high
//  req_valid in   1        request present
//  req_ready out  1        sequencer idle, can accept a request
//  req_op    in   2        00 add, 01 sub, 10 mul (radix-4), 11 div (SRT-2)
//  req_x     in   2*WIDTH  add/sub/mul: operand in [WIDTH-1:0]; div: dividend (hi->A, lo->Q)
//  req_y     in   WIDTH    second operand / multiplicand / divisor (loaded into M)
//  rsp_valid out  1        response held until accepted
//  rsp_ready in   1        consumer accepts response
//  rsp_hi    out  WIDTH    mul: A (product hi); div: remainder; add/sub: 0
//  rsp_lo    out  WIDTH    mul: Q (product lo); div: quotient; add/sub: result
//  rsp_timeout out 1       watchdog expired; rsp_hi/rsp_lo hold whatever was captured
//  BEGIN     out  1        one-cycle start pulse to the ALU control unit
//  op_code   out  2        operation code to the ALU, stable from START to RESPOND
//  inbus     out  WIDTH    operand word to the ALU
//  outbus    in   WIDTH    result word from the ALU
//  alu_push  in   1        ALU is in PUSHA/PUSHQ this cycle; outbus is valid
//  END       in   1        ALU completion indication
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=1. BEGIN=0. op_code=0. inbus=0. rsp_valid=0.
//    rsp_hi=0, rsp_lo=0, rsp_timeout=0. All counters=0.
//  Reset mid-operation: abort immediately, with the same values as reset. No response is produced.
//  States: IDLE -> START -> FEED -> COLLECT -> WAIT_END -> RESPOND -> IDLE.
//  IDLE: req_ready=1. On req_valid&req_ready, latch req_op/req_x/req_y, clear rsp_hi/rsp_lo, go to START.
//  START (1 cycle): BEGIN=1, op_code=latched op. The watchdog starts counting this cycle.
//    BEGIN is 1 in no other state, because the ALU acts on BEGIN in any state.
//  FEED: word index k=0..N-1, one word per cycle, starting the cycle after START.
//    add/sub: N=2, A=x[W-1:0], M=y.
//    mul: N=2, Q=x[W-1:0], M=y.
//    div: N=3, A=x[2W-1:W], Q=x[W-1:0], M=y.
//    After word N-1, go to COLLECT. inbus=0 in every state except FEED.
//  COLLECT: push counter p. Each cycle with alu_push=1 captures outbus:
//    add/sub: p0->rsp_lo.
//    mul: p0->rsp_hi (A), p1->rsp_lo (Q).
//    div: p0->rsp_lo (Q), p1->rsp_hi (A).
//    After the final push (1 for add/sub, 2 for mul/div), go to WAIT_END.
//    alu_push during START or FEED is ignored.
//  WAIT_END: go to RESPOND when END=1. If END=1 in the same cycle as the final push,
//    go straight from COLLECT to RESPOND. END before the final push is ignored.
//  RESPOND: rsp_valid=1, and rsp_hi/rsp_lo/rsp_timeout are stable.
//    On rsp_ready, go to IDLE; req_ready=1 on the next cycle.
//  op_code is held at the latched value from START through RESPOND, and is 0 in IDLE.
//  Watchdog: the count increments every cycle in START/FEED/COLLECT/WAIT_END.
//    When the count reaches TIMEOUT_CYCLES, go to RESPOND with rsp_timeout=1.
//    This takes priority over a simultaneous push or END.
//  Latency: req accept -> BEGIN is 1 cycle; the first inbus word follows BEGIN by 1 cycle.
//  Back-to-back requests: the earliest next accept is the cycle after the rsp handshake.
// TESTING (bench uses a behavioural ALU model honouring the load/push order above)
//  add 8'd5, 8'd3 -> BEGIN pulse 1 cycle; inbus 5 then 3; rsp_lo=8, rsp_hi=0, timeout=0.
//  mul x=8'hFD, y=8'h05 -> inbus FD then 05; {rsp_hi,rsp_lo}=16'hFFF1.
//  div x=16'd100, y=8'd7 -> inbus 00, 64, 07; rsp_lo=14, rsp_hi=2.
//  rsp_ready held low 5 cycles -> rsp_valid=1, data stable, req_ready=0 the whole time.
//  model never pushes -> rsp_valid with rsp_timeout=1 exactly 255 cycles after START.
//  reset asserted during FEED word 1 -> next cycle inbus=0, BEGIN=0, req_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/alu_host_sequencer_if.sv
// Bundle of the request/response handshake and the ALU control-unit bus.
// master: the sequencer side. slave: the system logic and ALU side.
interface alu_host_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [2*WIDTH-1:0]   req_x;
  logic [WIDTH-1:0]     req_y;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_hi;
  logic [WIDTH-1:0]     rsp_lo;
  logic                 rsp_timeout;
  logic                 BEGIN;
  logic [1:0]           op_code;
  logic [WIDTH-1:0]     inbus;
  logic [WIDTH-1:0]     outbus;
  logic                 alu_push;
  logic                 END;

  modport master (
    input  req_valid, req_op, req_x, req_y, rsp_ready, outbus, alu_push, END,
    output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_timeout, BEGIN, op_code, inbus
  );

  modport slave (
    output req_valid, req_op, req_x, req_y, rsp_ready, outbus, alu_push, END,
    input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_timeout, BEGIN, op_code, inbus
  );
endinterface

// File: rtl/alu_host_sequencer.sv
// Initiator for the ALU control unit: takes one request, pulses BEGIN, feeds
// the operand words in the ALU's load order, collects the pushed result words
// and presents them as a {hi,lo} response, with a watchdog against a stuck ALU.
module alu_host_sequencer #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_host_sequencer_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  // The count equals TIMEOUT_CYCLES in the first RESPOND cycle, so the
  // decision is taken one cycle earlier.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_COLLECT,
    S_WAIT_END,
    S_RESPOND
  } state_t;

  state_t state, next_state;

  // Latched request
  logic [1:0]           op_q;
  logic [2*WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]     y_q;

  // Counters and captured response
  logic [1:0]           k_cnt;
  logic                 p_cnt;
  logic [WD_W-1:0]      wdog;
  logic [WIDTH-1:0]     rsp_hi_q;
  logic [WIDTH-1:0]     rsp_lo_q;
  logic                 timeout_q;

  // Decoded control
  logic                 is_div;
  logic [1:0]           last_k;
  logic                 final_push;
  logic                 active;
  logic                 accept;
  logic                 cap_hi;
  logic                 cap_lo;
  logic                 wd_fire;
  logic [WIDTH-1:0]     feed_word;

  assign is_div     = (op_q == 2'b11);
  assign last_k     = is_div ? 2'd2 : 2'd1;
  // add/sub return one word; mul/div return two.
  assign final_push = op_q[1] ? p_cnt : 1'b1;
  assign active     = (state == S_START) || (state == S_FEED) ||
                      (state == S_COLLECT) || (state == S_WAIT_END);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state, operand word selection and capture strobes
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    cap_hi     = 1'b0;
    cap_lo     = 1'b0;
    wd_fire    = 1'b0;
    feed_word  = '0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = S_START;
        end
      end
      S_START: next_state = S_FEED;
      S_FEED: begin
        // div loads A, Q, M; the others load one operand then M.
        case (k_cnt)
          2'd0:    feed_word = is_div ? x_q[2*WIDTH-1:WIDTH] : x_q[WIDTH-1:0];
          2'd1:    feed_word = is_div ? x_q[WIDTH-1:0] : y_q;
          default: feed_word = y_q;
        endcase
        if (k_cnt == last_k) next_state = S_COLLECT;
      end
      S_COLLECT: begin
        if (bus.alu_push) begin
          // mul pushes A then Q; div pushes Q then A; add/sub push one result.
          cap_lo = ~op_q[1] | (is_div ? ~p_cnt : p_cnt);
          cap_hi =  op_q[1] & (is_div ?  p_cnt : ~p_cnt);
          if (final_push) next_state = bus.END ? S_RESPOND : S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        if (bus.END) next_state = S_RESPOND;
      end
      S_RESPOND: begin
        if (bus.rsp_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    // Watchdog expiry overrides any push or END seen in the same cycle.
    if (active && (wdog == WD_LAST)) begin
      wd_fire    = 1'b1;
      cap_hi     = 1'b0;
      cap_lo     = 1'b0;
      next_state = S_RESPOND;
    end
  end

  // Request capture; only read outside IDLE, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= bus.req_op;
      x_q  <= bus.req_x;
      y_q  <= bus.req_y;
    end
  end

  // Word/push/watchdog counters and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      k_cnt     <= '0;
      p_cnt     <= 1'b0;
      wdog      <= '0;
      rsp_hi_q  <= '0;
      rsp_lo_q  <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      k_cnt     <= '0;
      p_cnt     <= 1'b0;
      wdog      <= '0;
      rsp_hi_q  <= '0;
      rsp_lo_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (active)               wdog  <= wdog + 1'b1;
      if (state == S_FEED)      k_cnt <= k_cnt + 2'd1;
      if (cap_hi || cap_lo)     p_cnt <= ~p_cnt;
      if (cap_hi)               rsp_hi_q <= bus.outbus;
      if (cap_lo)               rsp_lo_q <= bus.outbus;
      if (wd_fire)              timeout_q <= 1'b1;
    end
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.rsp_valid   = (state == S_RESPOND);
  assign bus.BEGIN       = (state == S_START);
  assign bus.op_code     = (state == S_IDLE) ? 2'b00 : op_q;
  assign bus.inbus       = feed_word;
  assign bus.rsp_hi      = rsp_hi_q;
  assign bus.rsp_lo      = rsp_lo_q;
  assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Bench for alu_host_sequencer: a behavioural ALU answers BEGIN by loading the
// fed words and pushing results; requests are checked against arithmetic
// computed directly from the request fields.
module tb_alu_host_sequencer;
  localparam int W   = 8;
  localparam int TMO = 255;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_host_sequencer_if #(.WIDTH(W)) bus ();

  alu_host_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ALU model knobs set by the stimulus before each request
  int       push_gap  = 0;
  int       end_delay = 0;
  bit       early_end = 1'b0;
  bit       no_push   = 1'b0;
  logic [W-1:0] fed [3];
  int       fed_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic alu_cycle(input logic p, input logic [W-1:0] w, input logic e);
    @(posedge clk); #1;
    bus.alu_push = p;
    bus.outbus   = w;
    bus.END      = e;
  endtask

  // Behavioural ALU: loads words after BEGIN, computes, pushes in protocol order
  initial begin : alu_model
    logic [1:0]            op;
    int                    n, np;
    logic [W-1:0]          pw [2];
    logic signed [W-1:0]   qa, qm;
    logic signed [2*W-1:0] prod;
    logic [2*W-1:0]        dvd;
    bus.alu_push = 1'b0;
    bus.outbus   = '0;
    bus.END      = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.BEGIN === 1'b1) begin
        op = bus.op_code;
        n  = (op == 2'b11) ? 3 : 2;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          fed[i] = bus.inbus;
        end
        fed_n = n;
        np    = op[1] ? 2 : 1;
        pw[0] = '0;
        pw[1] = '0;
        case (op)
          2'b00: pw[0] = fed[0] + fed[1];
          2'b01: pw[0] = fed[0] - fed[1];
          2'b10: begin
            qa = fed[0];
            qm = fed[1];
            prod = qa * qm;
            pw[0] = prod[2*W-1:W];
            pw[1] = prod[W-1:0];
          end
          default: begin
            dvd = {fed[0], fed[1]};
            if (fed[2] == '0) begin
              pw[0] = '1;
              pw[1] = '1;
            end else begin
              pw[0] = W'(dvd / 16'(fed[2]));
              pw[1] = W'(dvd % 16'(fed[2]));
            end
          end
        endcase
        if (!no_push) begin
          for (int j = 0; j < np; j++) begin
            repeat (push_gap) alu_cycle(1'b0, '0, 1'b0);
            alu_cycle(1'b1, pw[j], (j == np - 1) ? (end_delay == 0) : early_end);
          end
          if (end_delay > 0) begin
            repeat (end_delay - 1) alu_cycle(1'b0, '0, 1'b0);
            alu_cycle(1'b0, '0, 1'b1);
          end
          alu_cycle(1'b0, '0, 1'b0);
        end
      end
    end
  end

  // One full transaction with reference expectations from the request fields
  task automatic run_req(input logic [1:0] op, input logic [2*W-1:0] x, input logic [W-1:0] y,
                         input int gap, input int edly, input int early, input int nopush,
                         input int rdly);
    logic [W-1:0]          exp_hi, exp_lo;
    logic [W-1:0]          exp_w [3];
    logic                  exp_to;
    logic signed [W-1:0]   xs, ys;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          hold_hi, hold_lo;
    int                    nw, np, exp_lat, n;
    bit                    got;

    nw = (op == 2'b11) ? 3 : 2;
    np = op[1] ? 2 : 1;
    exp_hi = '0;
    exp_to = 1'b0;
    case (op)
      2'b00: exp_lo = x[W-1:0] + y;
      2'b01: exp_lo = x[W-1:0] - y;
      2'b10: begin
        xs = x[W-1:0];
        ys = y;
        prod = xs * ys;
        exp_hi = prod[2*W-1:W];
        exp_lo = prod[W-1:0];
      end
      default: begin
        exp_lo = W'(x / 16'(y));
        exp_hi = W'(x % 16'(y));
      end
    endcase
    if (op == 2'b11) begin
      exp_w[0] = x[2*W-1:W];
      exp_w[1] = x[W-1:0];
      exp_w[2] = y;
    end else begin
      exp_w[0] = x[W-1:0];
      exp_w[1] = y;
      exp_w[2] = '0;
    end
    exp_lat = nw + np * (gap + 1) + edly + 1;
    if (nopush != 0) begin
      exp_hi  = '0;
      exp_lo  = '0;
      exp_to  = 1'b1;
      exp_lat = TMO;
    end

    push_gap  = gap;
    end_delay = edly;
    early_end = (early != 0);
    no_push   = (nopush != 0);
    fed_n     = 0;

    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_ready === 1'b1);
    end
    chk("req_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_x     = 16'($urandom);
    bus.req_y     = 8'($urandom);
    if (!got) return;

    @(negedge clk);
    chk("start_begin", 32'(bus.BEGIN), 32'd1);
    chk("start_op_code", 32'(bus.op_code), 32'(op));
    chk("start_inbus", 32'(bus.inbus), 32'd0);
    chk("start_req_ready", 32'(bus.req_ready), 32'd0);

    n = 0;
    got = 1'b0;
    while (n < TMO + 20 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("begin_one_cycle", 32'(bus.BEGIN), 32'd0);
        chk("inbus_word0", 32'(bus.inbus), 32'(exp_w[0]));
      end
      got = (bus.rsp_valid === 1'b1);
    end
    chk("rsp_latency", 32'(n), 32'(exp_lat));
    chk("rsp_hi", 32'(bus.rsp_hi), 32'(exp_hi));
    chk("rsp_lo", 32'(bus.rsp_lo), 32'(exp_lo));
    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
    chk("respond_op_code", 32'(bus.op_code), 32'(op));
    hold_hi = bus.rsp_hi;
    hold_lo = bus.rsp_lo;

    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_rsp_lo", 32'(bus.rsp_lo), 32'(hold_lo));
      chk("hold_rsp_hi", 32'(bus.rsp_hi), 32'(hold_hi));
    end

    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_op_code", 32'(bus.op_code), 32'd0);

    chk("fed_count", 32'(fed_n), 32'(nw));
    for (int i = 0; i < nw; i++) chk("fed_word", 32'(fed[i]), 32'(exp_w[i]));
  endtask

  // Stimulus
  initial begin : stim
    logic [1:0]       rop;
    logic [2*W-1:0]   rx;
    logic [W-1:0]     ry;
    int               yi;
    bit               got;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_begin", 32'(bus.BEGIN), 32'd0);
    chk("rst_op_code", 32'(bus.op_code), 32'd0);
    chk("rst_inbus", 32'(bus.inbus), 32'd0);
    chk("rst_rsp_hi", 32'(bus.rsp_hi), 32'd0);
    chk("rst_rsp_lo", 32'(bus.rsp_lo), 32'd0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    run_req(2'b00, 16'h0005, 8'h03, 0, 0, 0, 0, 0);
    run_req(2'b10, 16'h00FD, 8'h05, 0, 0, 0, 0, 1);
    run_req(2'b11, 16'd100,  8'd7,  1, 2, 0, 0, 0);
    run_req(2'b01, 16'h0010, 8'h20, 0, 1, 0, 0, 5);
    run_req(2'b10, 16'h0037, 8'h9C, 1, 2, 1, 0, 0);
    run_req(2'b11, 16'h0581, 8'h0B, 0, 0, 1, 0, 2);
    run_req(2'b10, 16'h00FD, 8'h05, 0, 0, 0, 1, 0);

    // Reset during the second FEED word of a divide
    push_gap = 0; end_delay = 0; early_end = 1'b0; no_push = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    bus.req_x     = 16'h1234;
    bus.req_y     = 8'h56;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_ready === 1'b1);
    end
    chk("rstop_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstop_begin", 32'(bus.BEGIN), 32'd1);
    @(negedge clk);
    chk("rstop_word0", 32'(bus.inbus), 32'h12);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstop_word1", 32'(bus.inbus), 32'h34);
    @(negedge clk);
    chk("rstop_inbus", 32'(bus.inbus), 32'd0);
    chk("rstop_begin_low", 32'(bus.BEGIN), 32'd0);
    chk("rstop_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstop_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstop_op_code", 32'(bus.op_code), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstop_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rstop_idle", 32'(bus.req_ready), 32'd1);

    // Randomized requests
    for (int t = 0; t < 24; t++) begin
      rop = 2'($urandom_range(0, 3));
      rx  = 16'($urandom);
      ry  = 8'($urandom);
      if (rop == 2'b11) begin
        ry = 8'($urandom_range(1, 255));
        yi = int'(ry);
        rx[2*W-1:W] = 8'($urandom_range(0, yi - 1));
      end
      run_req(rop, rx, ry, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), 0, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time budget
  initial begin : budget
    #400000;
    $display("FAIL global_timeout: got no finish want finish before budget");
    $fatal(1, "time budget exhausted");
  end

endmodule
